// File: rtl/misaligned_lsu_seq_pkg.sv
// Shared types for the misaligned load/store sequencer: access sizes, FSM states
// and the size-legality check that depends on the datapath width.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

    // Doubleword accesses only exist on a 64-bit datapath.
    function automatic logic size_legal(input logic [1:0] size, input int xlen);
        return (size != SZ_D) || (xlen == 64);
    endfunction

endpackage

// File: rtl/misaligned_lsu_seq_byte_lane_align.sv
// Byte-lane steering for one access: per-beat strobes and store data, plus the
// load extract from the two captured beats with sign/zero extension.
module byte_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BYTES = XLEN / 8,
    localparam int OFFW = $clog2(BYTES)
) (
    input  logic [OFFW-1:0]  off,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  lo,
    input  logic [XLEN-1:0]  hi,
    output logic [BYTES-1:0] wstrb0,
    output logic [BYTES-1:0] wstrb1,
    output logic [XLEN-1:0]  wdata0,
    output logic [XLEN-1:0]  wdata1,
    output logic [XLEN-1:0]  rdata
);

    logic [3:0]         nbytes;
    logic [2*BYTES-1:0] mask;
    logic [2*BYTES-1:0] wstrb_full;
    logic [OFFW+2:0]    lane_shift;
    logic [OFFW+3:0]    hi_shift;
    logic [XLEN-1:0]    raw;
    logic [XLEN-1:0]    keep;
    logic               sgn;

    assign nbytes = 4'd1 << size;

    // mask is the (1<<nbytes)-1 pattern, built bit by bit across both beats
    for (genvar gi = 0; gi < 2*BYTES; gi++) begin : g_mask
        assign mask[gi] = (nbytes > 4'(gi));
    end

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
        assign keep[8*gi +: 8] = {8{nbytes > 4'(gi)}};
    end

    assign wstrb_full = mask << off;
    assign wstrb0     = wstrb_full[BYTES-1:0];
    assign wstrb1     = wstrb_full[2*BYTES-1:BYTES];

    assign lane_shift = {off, 3'b000};
    assign hi_shift   = (OFFW+4)'(8*BYTES) - {1'b0, lane_shift};
    assign wdata0     = wdata << lane_shift;
    assign wdata1     = wdata >> hi_shift;

    assign raw = XLEN'({hi, lo} >> lane_shift);

    always_comb begin
        sgn = raw[XLEN-1];
        case (size_e'(size))
            SZ_B:    sgn = raw[7];
            SZ_H:    sgn = raw[15];
            SZ_W:    sgn = raw[31];
            default: sgn = raw[XLEN-1];
        endcase
        rdata = (raw & keep) | ((sgn && !is_unsigned) ? ~keep : '0);
    end

endmodule

// File: rtl/misaligned_lsu_seq.sv
// Load/store sequencer: splits word-crossing accesses into two aligned bus beats,
// reassembles load data and holds a single response until it is consumed.
module misaligned_lsu_seq
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_fault,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_wstrb,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [31:0]           split_count
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       hi_q, hi_d;
    logic                  split_q, split_d;
    logic                  fault_q, fault_d;
    logic [31:0]           split_count_q, split_count_d;

    logic [OFFW+1:0]       req_end;
    logic                  req_split;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [BYTES-1:0]      wstrb0, wstrb1;
    logic [XLEN-1:0]       wdata0, wdata1, load_data;

    // End offset of the request inside its word; wide enough that off+8 cannot wrap.
    assign req_end   = (OFFW+2)'(req_addr[OFFW-1:0]) + ((OFFW+2)'(1) << req_size);
    assign req_split = (req_end > (OFFW+2)'(BYTES));
    assign word_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

    byte_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .off        (addr_q[OFFW-1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .lo         (lo_q),
        .hi         (hi_q),
        .wstrb0     (wstrb0),
        .wstrb1     (wstrb1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .rdata      (load_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        we_d          = we_q;
        uns_d         = uns_q;
        wdata_d       = wdata_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        split_d       = split_q;
        fault_d       = fault_q;
        split_count_d = split_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    hi_d    = '0;
                    split_d = req_split;
                    if (!size_legal(req_size, XLEN) || (req_split && !ALLOW_MISALIGNED)) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                if (mem_ready) begin
                    lo_d    = mem_rdata;
                    state_d = split_q ? ACC1 : RESP;
                end
            end
            ACC1: begin
                if (mem_ready) begin
                    hi_d          = mem_rdata;
                    split_count_d = split_count_q + 32'd1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        mem_valid = 1'b0;
        mem_addr  = word_addr;
        mem_wstrb = '0;
        mem_wdata = '0;
        case (state_q)
            ACC0: begin
                mem_valid = 1'b1;
                mem_wstrb = we_q ? wstrb0 : '0;
                mem_wdata = wdata0;
            end
            ACC1: begin
                mem_valid = 1'b1;
                mem_addr  = word_addr + ADDR_WIDTH'(BYTES);
                mem_wstrb = we_q ? wstrb1 : '0;
                mem_wdata = wdata1;
            end
            default: ;
        endcase
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_fault   = rsp_valid && fault_q;
    assign rsp_rdata   = (rsp_valid && !we_q && !fault_q) ? load_data : '0;
    assign split_count = split_count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            wdata_q       <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            split_q       <= 1'b0;
            fault_q       <= 1'b0;
            split_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            we_q          <= we_d;
            uns_q         <= uns_d;
            wdata_q       <= wdata_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            split_q       <= split_d;
            fault_q       <= fault_d;
            split_count_q <= split_count_d;
        end
    end

endmodule

// File: tb/tb_misaligned_lsu_seq.sv
// Directed bench for misaligned_lsu_seq: three instances (32-bit, 64-bit,
// 32-bit faulting) share stimulus; a vector table drives them one at a time.
module tb_misaligned_lsu_seq;

    logic        clk = 1'b0;
    logic        resetn;
    int          sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_fault, a_mem_valid;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata, a_split_count;
    logic [3:0]  a_mem_wstrb;
    logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_valid;
    logic [63:0] b_rsp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr, b_split_count;
    logic [7:0]  b_mem_wstrb;
    logic        c_req_ready, c_rsp_valid, c_rsp_fault, c_mem_valid;
    logic [31:0] c_rsp_rdata, c_mem_addr, c_mem_wdata, c_split_count;
    logic [3:0]  c_mem_wstrb;

    logic        o_req_ready, o_rsp_valid, o_rsp_fault, o_mem_valid;
    logic [63:0] o_rsp_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr, o_split_count;
    logic [7:0]  o_mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    misaligned_lsu_seq #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut32 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid && sel == 0), .req_ready(a_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
        .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
        .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata[31:0]),
        .split_count(a_split_count)
    );

    misaligned_lsu_seq #(.XLEN(64), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut64 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid && sel == 1), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
        .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .split_count(b_split_count)
    );

    misaligned_lsu_seq #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dutf (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid && sel == 2), .req_ready(c_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(c_rsp_rdata), .rsp_fault(c_rsp_fault),
        .mem_valid(c_mem_valid), .mem_ready(mem_ready), .mem_addr(c_mem_addr),
        .mem_wstrb(c_mem_wstrb), .mem_wdata(c_mem_wdata), .mem_rdata(mem_rdata[31:0]),
        .split_count(c_split_count)
    );

    always_comb begin
        o_req_ready   = a_req_ready;
        o_rsp_valid   = a_rsp_valid;
        o_rsp_fault   = a_rsp_fault;
        o_rsp_rdata   = {32'd0, a_rsp_rdata};
        o_mem_valid   = a_mem_valid;
        o_mem_addr    = a_mem_addr;
        o_mem_wstrb   = {4'd0, a_mem_wstrb};
        o_mem_wdata   = {32'd0, a_mem_wdata};
        o_split_count = a_split_count;
        if (sel == 1) begin
            o_req_ready   = b_req_ready;
            o_rsp_valid   = b_rsp_valid;
            o_rsp_fault   = b_rsp_fault;
            o_rsp_rdata   = b_rsp_rdata;
            o_mem_valid   = b_mem_valid;
            o_mem_addr    = b_mem_addr;
            o_mem_wstrb   = b_mem_wstrb;
            o_mem_wdata   = b_mem_wdata;
            o_split_count = b_split_count;
        end else if (sel == 2) begin
            o_req_ready   = c_req_ready;
            o_rsp_valid   = c_rsp_valid;
            o_rsp_fault   = c_rsp_fault;
            o_rsp_rdata   = {32'd0, c_rsp_rdata};
            o_mem_valid   = c_mem_valid;
            o_mem_addr    = c_mem_addr;
            o_mem_wstrb   = {4'd0, c_mem_wstrb};
            o_mem_wdata   = {32'd0, c_mem_wdata};
            o_split_count = c_split_count;
        end
    end

    typedef struct {
        int          sel;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata, rd0, rd1;
        int          stall;
        int          e_nb, e_lat;
        logic [31:0] e_a0;
        logic [7:0]  e_s0;
        logic [63:0] e_w0;
        logic [31:0] e_a1;
        logic [7:0]  e_s1;
        logic [63:0] e_w1, e_rdata;
        logic        e_fault;
        int          e_delta;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ba [4];
        logic [7:0]  bs [4];
        logic [63:0] bw [4];
        int          nb, cyc, stall_cnt;
        logic        unstable;
        logic [31:0] cnt0;
        sel          = v.sel;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        mem_ready    = 1'b0;
        rsp_ready    = 1'b0;
        req_valid    = 1'b1;
        #1;
        cnt0 = o_split_count;
        chk($sformatf("v%0d_req_ready", idx), 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        nb = 0; cyc = 0; stall_cnt = 0; unstable = 1'b0;
        while (!o_rsp_valid && cyc < 100) begin
            if (o_mem_valid) begin
                if (stall_cnt == 0) begin
                    if (nb < 4) begin
                        ba[nb] = o_mem_addr; bs[nb] = o_mem_wstrb; bw[nb] = o_mem_wdata;
                    end
                end else if (nb < 4 && (o_mem_addr !== ba[nb] || o_mem_wstrb !== bs[nb] ||
                                        o_mem_wdata !== bw[nb])) begin
                    unstable = 1'b1;
                end
                if (stall_cnt < v.stall) begin
                    mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = (nb == 0) ? v.rd0 : v.rd1;
                    stall_cnt = 0;
                    nb++;
                end
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ready = 1'b0;
        $display("vec %0d: dut %0d addr 0x%08h beats %0d latency %0d rdata 0x%0h fault %0b",
                 idx, v.sel, v.addr, nb, cyc + 1, o_rsp_rdata, o_rsp_fault);
        chk($sformatf("v%0d_rsp_valid", idx), 64'(o_rsp_valid), 64'd1);
        chk($sformatf("v%0d_latency", idx), 64'(cyc + 1), 64'(v.e_lat));
        chk($sformatf("v%0d_beats", idx), 64'(nb), 64'(v.e_nb));
        if (v.e_nb >= 1 && nb >= 1) begin
            chk($sformatf("v%0d_addr0", idx), 64'(ba[0]), 64'(v.e_a0));
            chk($sformatf("v%0d_wstrb0", idx), 64'(bs[0]), 64'(v.e_s0));
            chk($sformatf("v%0d_wdata0", idx), bw[0], v.e_w0);
        end
        if (v.e_nb >= 2 && nb >= 2) begin
            chk($sformatf("v%0d_addr1", idx), 64'(ba[1]), 64'(v.e_a1));
            chk($sformatf("v%0d_wstrb1", idx), 64'(bs[1]), 64'(v.e_s1));
            chk($sformatf("v%0d_wdata1", idx), bw[1], v.e_w1);
        end
        if (v.stall > 0) chk($sformatf("v%0d_stall_unstable", idx), 64'(unstable), 64'd0);
        chk($sformatf("v%0d_rdata", idx), o_rsp_rdata, v.e_rdata);
        chk($sformatf("v%0d_fault", idx), 64'(o_rsp_fault), 64'(v.e_fault));
        chk($sformatf("v%0d_split_delta", idx), 64'(o_split_count - cnt0), 64'(v.e_delta));
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("v%0d_rsp_held", idx), 64'(o_rsp_valid), 64'd1);
        chk($sformatf("v%0d_rdata_held", idx), o_rsp_rdata, v.e_rdata);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_ready_after_rsp", idx), 64'(o_req_ready), 64'd1);
        chk($sformatf("v%0d_rsp_dropped", idx), 64'(o_rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         sel we sz un addr            wdata                   rd0                     rd1                     st nb lat a0            s0     w0                      a1            s1    w1          rdata                   flt dlt
        vecs[0]  = '{0, 0, 2, 0, 32'h0000_1002, 64'h0,                 64'hAABBCCDD,           64'h11223344,           0, 2, 3, 32'h0000_1000, 8'h0,  64'h0,                  32'h0000_1004, 8'h0, 64'h0,      64'h3344AABB,           0, 1};
        vecs[1]  = '{0, 1, 1, 0, 32'h0000_2003, 64'hBEEF,              64'h0,                  64'h0,                  0, 2, 3, 32'h0000_2000, 8'h8,  64'hEF000000,           32'h0000_2004, 8'h1, 64'hBE,     64'h0,                  0, 1};
        vecs[2]  = '{1, 0, 0, 0, 32'h0000_0007, 64'h0,                 64'h8011223344556677,   64'h0,                  0, 1, 2, 32'h0000_0000, 8'h0,  64'h0,                  32'h0,         8'h0, 64'h0,      64'hFFFFFFFFFFFFFF80,   0, 0};
        vecs[3]  = '{2, 0, 2, 0, 32'h0000_0001, 64'h0,                 64'h0,                  64'h0,                  0, 0, 1, 32'h0,         8'h0,  64'h0,                  32'h0,         8'h0, 64'h0,      64'h0,                  1, 0};
        vecs[4]  = '{0, 0, 3, 0, 32'h0000_0000, 64'h0,                 64'h0,                  64'h0,                  0, 0, 1, 32'h0,         8'h0,  64'h0,                  32'h0,         8'h0, 64'h0,      64'h0,                  1, 0};
        vecs[5]  = '{2, 0, 2, 0, 32'h0000_0100, 64'h0,                 64'h12345678,           64'h0,                  0, 1, 2, 32'h0000_0100, 8'h0,  64'h0,                  32'h0,         8'h0, 64'h0,      64'h12345678,           0, 0};
        vecs[6]  = '{0, 1, 2, 0, 32'hFFFF_FFFE, 64'hCAFEF00D,          64'h0,                  64'h0,                  3, 2, 9, 32'hFFFF_FFFC, 8'hC,  64'hF00D0000,           32'h0000_0000, 8'h3, 64'hCAFE,   64'h0,                  0, 1};
        vecs[7]  = '{1, 0, 1, 1, 32'h0000_0007, 64'h0,                 64'hAB11223344556677,   64'h99887766554433CD,   0, 2, 3, 32'h0000_0000, 8'h0,  64'h0,                  32'h0000_0008, 8'h0, 64'h0,      64'h000000000000CDAB,   0, 1};
        vecs[8]  = '{1, 0, 1, 0, 32'h0000_0007, 64'h0,                 64'hAB11223344556677,   64'h99887766554433CD,   0, 2, 3, 32'h0000_0000, 8'h0,  64'h0,                  32'h0000_0008, 8'h0, 64'h0,      64'hFFFFFFFFFFFFCDAB,   0, 1};
        vecs[9]  = '{1, 1, 3, 0, 32'h0000_0010, 64'h0123456789ABCDEF,  64'h0,                  64'h0,                  1, 1, 3, 32'h0000_0010, 8'hFF, 64'h0123456789ABCDEF,   32'h0,         8'h0, 64'h0,      64'h0,                  0, 0};
        vecs[10] = '{0, 0, 0, 0, 32'h0000_0003, 64'h0,                 64'h7F000000,           64'h0,                  0, 1, 2, 32'h0000_0000, 8'h0,  64'h0,                  32'h0,         8'h0, 64'h0,      64'h7F,                 0, 0};
        vecs[11] = '{1, 1, 2, 0, 32'h0000_0006, 64'h11223344,          64'h0,                  64'h0,                  0, 2, 3, 32'h0000_0000, 8'hC0, 64'h3344000000000000,   32'h0000_0008, 8'h3, 64'h1122,   64'h0,                  0, 1};

        sel = 0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("reset_req_ready", 64'(o_req_ready), 64'd1);
        chk("reset_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("reset_mem_wstrb", 64'(o_mem_wstrb), 64'd0);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("reset_rsp_fault", 64'(o_rsp_fault), 64'd0);
        chk("reset_rsp_rdata", o_rsp_rdata, 64'd0);
        chk("reset_split_count", 64'(o_split_count), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted while the second beat of a split load is stalled.
        sel = 0; #1;
        chk("pre_reset_split_count", 64'(o_split_count), 64'd3);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_1002;
        req_wdata = '0; mem_rdata = 64'hAABBCCDD; mem_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("acc1_mem_valid", 64'(o_mem_valid), 64'd1);
        chk("acc1_mem_addr", 64'(o_mem_addr), 64'h1004);
        #2;
        resetn = 1'b0;
        #1;
        $display("reset during ACC1: mem_valid %0b req_ready %0b split_count %0d",
                 o_mem_valid, o_req_ready, o_split_count);
        chk("midrst_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("midrst_req_ready", 64'(o_req_ready), 64'd1);
        chk("midrst_split_count", 64'(o_split_count), 64'd0);
        chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], NVEC);
        chk("post_reset_split_count", 64'(o_split_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
